// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus store operand into a
// single byte/halfword/word data-memory access over a req/ready handshake and
// returns the sign- or zero-extended load result. Illegal or misaligned
// accesses are rejected without touching memory.
module lsu (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Misaligned,
    output logic [31:0] ReadData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBE,
    input  logic [31:0] MemRData,
    input  logic        MemReady
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Funct3 legality and natural alignment for the requested access size.
    function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal_v;
        logic aligned_v;
        if (we) begin
            legal_v = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            legal_v = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
        case (f3[1:0])
            2'b00:   aligned_v = 1'b1;
            2'b01:   aligned_v = (a[0] == 1'b0);
            2'b10:   aligned_v = (a == 2'b00);
            default: aligned_v = 1'b0;
        endcase
        return legal_v && aligned_v;
    endfunction

    // Byte-lane enables within the addressed word.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be_v;
        case (f3[1:0])
            2'b00:   be_v = 4'b0001 << a;
            2'b01:   be_v = 4'b0011 << {a[1], 1'b0};
            2'b10:   be_v = 4'b1111;
            default: be_v = 4'b0000;
        endcase
        return be_v;
    endfunction

    // Store data replicated across lanes so the byte enables select the right one.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] sd_v;
        case (f3[1:0])
            2'b00:   sd_v = {4{wd[7:0]}};
            2'b01:   sd_v = {2{wd[15:0]}};
            2'b10:   sd_v = wd;
            default: sd_v = 32'h0000_0000;
        endcase
        return sd_v;
    endfunction

    // Lane extraction and sign/zero extension of the returned memory word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] shifted_v;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] ld_v;
        shifted_v = rdata >> {a, 3'b000};
        byte_v    = shifted_v[7:0];
        half_v    = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  ld_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  ld_v = {{16{half_v[15]}}, half_v};
            3'b010:  ld_v = rdata;
            3'b100:  ld_v = {24'h00_0000, byte_v};
            3'b101:  ld_v = {16'h0000, half_v};
            default: ld_v = 32'h0000_0000;
        endcase
        return ld_v;
    endfunction

    state_t      state_r, state_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        misaligned_r, misaligned_s;
    logic [31:0] read_data_r, read_data_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic [3:0]  mem_be_r, mem_be_s;
    logic        we_r, we_s;
    logic [2:0]  f3_r, f3_s;
    logic [1:0]  a_r, a_s;

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        state_s      = state_r;
        busy_s       = busy_r;
        done_s       = done_r;
        misaligned_s = misaligned_r;
        read_data_s  = read_data_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_be_s     = mem_be_r;
        we_s         = we_r;
        f3_s         = f3_r;
        a_s          = a_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    we_s   = MemWrite;
                    f3_s   = Funct3;
                    a_s    = ALUResult[1:0];
                    busy_s = 1'b1;
                    if (access_ok(MemWrite, Funct3, ALUResult[1:0])) begin
                        state_s      = REQ;
                        mem_req_s    = 1'b1;
                        mem_we_s     = MemWrite;
                        mem_addr_s   = {ALUResult[31:2], 2'b00};
                        mem_be_s     = byte_enable(Funct3, ALUResult[1:0]);
                        mem_wdata_s  = store_data(Funct3, WriteData);
                        done_s       = 1'b0;
                        misaligned_s = 1'b0;
                    end else begin
                        // Rejected: skip memory entirely and report straight away.
                        state_s      = DONE;
                        mem_req_s    = 1'b0;
                        mem_we_s     = 1'b0;
                        done_s       = 1'b1;
                        misaligned_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            REQ: begin
                if (MemReady) begin
                    state_s      = DONE;
                    mem_req_s    = 1'b0;
                    mem_we_s     = 1'b0;
                    done_s       = 1'b1;
                    misaligned_s = 1'b0;
                    if (!we_r) begin
                        read_data_s = load_extend(f3_r, a_r, MemRData);
                    end else begin
                        read_data_s = read_data_r;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DONE: begin
                state_s      = IDLE;
                busy_s       = 1'b0;
                done_s       = 1'b0;
                misaligned_s = 1'b0;
            end
            default: begin
                state_s      = IDLE;
                busy_s       = 1'b0;
                done_s       = 1'b0;
                misaligned_s = 1'b0;
                mem_req_s    = 1'b0;
                mem_we_s     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and aborts any access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            read_data_r  <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_be_r     <= 4'b0000;
            we_r         <= 1'b0;
            f3_r         <= 3'b000;
            a_r          <= 2'b00;
        end else begin
            state_r      <= state_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            misaligned_r <= misaligned_s;
            read_data_r  <= read_data_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_be_r     <= mem_be_s;
            we_r         <= we_s;
            f3_r         <= f3_s;
            a_r          <= a_s;
        end
    end

    assign Busy       = busy_r;
    assign Done       = done_r;
    assign Misaligned = misaligned_r;
    assign ReadData   = read_data_r;
    assign MemReq     = mem_req_r;
    assign MemWe      = mem_we_r;
    assign MemAddr    = mem_addr_r;
    assign MemWData   = mem_wdata_r;
    assign MemBE      = mem_be_r;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a small byte-enabled memory model.
module tb_lsu;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Misaligned;
    logic [31:0] ReadData;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic [31:0] MemRData;
    logic        MemReady;

    logic [31:0] mem [0:255];
    int n_cmp;
    int n_err;
    int cyc;
    int first_req_cyc;

    lsu dut (
        .CLK(CLK), .RST(RST), .Start(Start), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .Busy(Busy), .Done(Done),
        .Misaligned(Misaligned), .ReadData(ReadData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE), .MemRData(MemRData),
        .MemReady(MemReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle counter for latency measurements
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: combinational read, byte-enabled write when the handshake completes
    assign MemRData = mem[MemAddr[9:2]];
    always @(posedge CLK) begin
        if (MemReq && MemWe && MemReady) begin
            for (int b = 0; b < 4; b++) begin
                if (MemBE[b]) mem[MemAddr[9:2]][8*b +: 8] <= MemWData[8*b +: 8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " Busy"}, {31'd0, Busy}, 32'd0);
        check({tag, " Done"}, {31'd0, Done}, 32'd0);
        check({tag, " Misaligned"}, {31'd0, Misaligned}, 32'd0);
        check({tag, " ReadData"}, ReadData, 32'd0);
        check({tag, " MemReq"}, {31'd0, MemReq}, 32'd0);
        check({tag, " MemWe"}, {31'd0, MemWe}, 32'd0);
        check({tag, " MemAddr"}, MemAddr, 32'd0);
        check({tag, " MemWData"}, MemWData, 32'd0);
        check({tag, " MemBE"}, {28'd0, MemBE}, 32'd0);
    endtask

    // Drives Start for exactly one sampling edge (edge 0), returns just after it
    task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
        Start     = 1'b1;
        MemWrite  = we;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
        tick();
        Start     = 1'b0;
        ALUResult = 32'hDEAD_BEEF;
        WriteData = 32'h5A5A_5A5A;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        start_op(1'b0, f3, addr, 32'd0);
        check({tag, " req"}, {31'd0, MemReq}, 32'd1);
        tick();
        check({tag, " done"}, {31'd0, Done}, 32'd1);
        check({tag, " data"}, ReadData, exp);
        tick();
        check({tag, " idle"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic do_reject(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] prev_rd);
        start_op(we, f3, addr, 32'h1111_2222);
        check({tag, " done"}, {31'd0, Done}, 32'd1);
        check({tag, " mis"}, {31'd0, Misaligned}, 32'd1);
        check({tag, " noreq"}, {31'd0, MemReq}, 32'd0);
        check({tag, " rd held"}, ReadData, prev_rd);
        tick();
        check({tag, " done drop"}, {31'd0, Done}, 32'd0);
        check({tag, " noreq2"}, {31'd0, MemReq}, 32'd0);
        check({tag, " idle"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        RST = 1'b1; Start = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'd0; WriteData = 32'd0; MemReady = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // Reset in the middle of an access
        MemReady = 1'b0;
        start_op(1'b0, 3'b010, 32'h0000_2000, 32'd0);
        check("rstmid req", {31'd0, MemReq}, 32'd1);
        check("rstmid busy", {31'd0, Busy}, 32'd1);
        RST = 1'b1;
        #1;
        check_all_zero("rstmid async");
        tick();
        check("rstmid nodone", {31'd0, Done}, 32'd0);
        RST = 1'b0;
        MemReady = 1'b1;
        tick();
        check("rstmid nodone2", {31'd0, Done}, 32'd0);

        // Store byte with lane replication
        start_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        check("sb req", {31'd0, MemReq}, 32'd1);
        check("sb we", {31'd0, MemWe}, 32'd1);
        check("sb addr", MemAddr, 32'h0000_1000);
        check("sb be", {28'd0, MemBE}, 32'h0000_0008);
        check("sb wdata", MemWData, 32'hA5A5_A5A5);
        check("sb done early", {31'd0, Done}, 32'd0);
        tick();
        check("sb done", {31'd0, Done}, 32'd1);
        check("sb mis", {31'd0, Misaligned}, 32'd0);
        check("sb req drop", {31'd0, MemReq}, 32'd0);
        tick();
        check("sb done pulse", {31'd0, Done}, 32'd0);
        check("sb mem", mem[0], 32'hA500_0000);

        // Loads with sign/zero extension
        mem[0] = 32'h80FF_7F01;
        do_load("lb",  3'b000, 32'h0000_2002, 32'hFFFF_FFFF);
        do_load("lbu", 3'b100, 32'h0000_2003, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_2002, 32'hFFFF_80FF);
        do_load("lhu", 3'b101, 32'h0000_2000, 32'h0000_7F01);
        do_load("lb0", 3'b000, 32'h0000_2000, 32'h0000_0001);

        // Wait states plus a Start pulse while busy
        mem[0] = 32'hCAFE_BABE;
        MemReady = 1'b0;
        start_op(1'b0, 3'b010, 32'h0000_3000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("ws req", {31'd0, MemReq}, 32'd1);
            check("ws addr", MemAddr, 32'h0000_3000);
            check("ws be", {28'd0, MemBE}, 32'h0000_000F);
            check("ws nodone", {31'd0, Done}, 32'd0);
            if (i == 1) begin
                Start = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_5554;
            end else begin
                Start = 1'b0;
            end
            if (i == 3) MemReady = 1'b1;
            tick();
        end
        check("ws done", {31'd0, Done}, 32'd1);
        check("ws data", ReadData, 32'hCAFE_BABE);
        tick();
        check("ws idle", {31'd0, Busy}, 32'd0);
        check("ws ignored start", {31'd0, MemReq}, 32'd0);

        // Rejected accesses
        do_reject("lw mis", 1'b0, 3'b010, 32'h0000_3002, 32'hCAFE_BABE);
        do_reject("sh mis", 1'b1, 3'b001, 32'h0000_3001, 32'hCAFE_BABE);
        do_reject("ld f3 011", 1'b0, 3'b011, 32'h0000_3000, 32'hCAFE_BABE);
        do_reject("st f3 100", 1'b1, 3'b100, 32'h0000_3000, 32'hCAFE_BABE);

        // Back-to-back SW then LW
        mem[0] = 32'd0;
        start_op(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678);
        first_req_cyc = cyc;
        check("b2b sw req", {31'd0, MemReq}, 32'd1);
        tick();
        check("b2b sw done", {31'd0, Done}, 32'd1);
        tick();
        start_op(1'b0, 3'b010, 32'h0000_4000, 32'd0);
        check("b2b lw req", {31'd0, MemReq}, 32'd1);
        check("b2b lw we", {31'd0, MemWe}, 32'd0);
        check("b2b spacing", cyc - first_req_cyc, 32'd3);
        tick();
        check("b2b lw done", {31'd0, Done}, 32'd1);
        check("b2b lw data", ReadData, 32'h1234_5678);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
